sdpb_ram_1kx32: RTL and testbench

Single-clock semi-dual-port block RAM, 1024 words × 32 bits, with one write port (A) and one registered read port (B). It serves as a row/line buffer between a pixel producer (port A) and a memory-controller consumer (port B). Two 16-bit pixels are packed per word, so a 640-pixel row uses addresses 0..319.

---
 rtl/sdpb_ram_1kx32.sv | 34 +++
 tb/tb_sdpb_ram_1kx32.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sdpb_ram_1kx32.sv
// sdpb_ram_1kx32: 1024x32 semi-dual-port RAM, one write port and one registered read port.
// Define SDPB_OUTPUT_REG_EN to add an oce-gated second output register (2-cycle read latency).
module sdpb_ram_1kx32 #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cea,
  input  logic [ADDR_WIDTH-1:0] ada,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  ceb,
  input  logic [ADDR_WIDTH-1:0] adb,
  input  logic                  oce,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_d, rd_q;
  // The array has no reset, so writes still commit while reset_n is low
  always_ff @(posedge clk)
    if (cea) mem[ada] <= din;
  always_comb rd_d = ceb ? mem[adb] : rd_q;
  always_ff @(posedge clk) rd_q <= reset_n ? rd_d : '0;
`ifdef SDPB_OUTPUT_REG_EN
  logic [DATA_WIDTH-1:0] out_d, out_q;
  always_comb out_d = oce ? rd_q : out_q;
  always_ff @(posedge clk) out_q <= reset_n ? out_d : '0;
  assign dout = out_q;
`else
  logic unused_oce;
  assign unused_oce = oce;
  assign dout = rd_q;
`endif
endmodule

// File: tb/tb_sdpb_ram_1kx32.sv
// tb_sdpb_ram_1kx32: scoreboard bench for sdpb_ram_1kx32; read expectations are queued with a due cycle.
module tb_sdpb_ram_1kx32;
`ifdef SDPB_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic        clk = 0;
  logic        reset_n = 0;
  logic        cea = 0;
  logic [9:0]  ada = 0;
  logic [31:0] din = 0;
  logic        ceb = 0;
  logic [9:0]  adb = 0;
  logic        oce = 0;
  logic [31:0] dout;

  typedef struct {
    int          due;
    logic [31:0] val;
    logic [9:0]  adr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [1024];
  int          cycle = 0;
  int          checks = 0;
  int          errors = 0;

  sdpb_ram_1kx32 dut (
    .clk(clk), .reset_n(reset_n), .cea(cea), .ada(ada), .din(din),
    .ceb(ceb), .adb(adb), .oce(oce), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rn, input logic a_en, input logic [9:0] a, input logic [31:0] d,
                      input logic b_en, input logic [9:0] b, input logic oe);
    exp_t e;
    reset_n = rn; cea = a_en; ada = a; din = d; ceb = b_en; adb = b; oce = oe;
    @(posedge clk);
    cycle++;
    if (!rn) sb.delete();
    if (b_en && rn && (LAT == 1 || oe)) sb.push_back('{cycle + LAT - 1, model[b], b});
    if (a_en) model[a] = d;
    #1;
    while (sb.size() > 0 && sb[0].due == cycle) begin
      e = sb.pop_front();
      checks++;
      if (dout !== e.val) begin
        errors++;
        $display("FAIL read adb=%0d at cycle %0d: dout=%h expected %h", e.adr, cycle, dout, e.val);
      end
    end
  endtask

  task automatic drain;
    repeat (LAT) step(1, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 5, 32'hA5A5A5A5, 1, 5, 1);
      checks++;
      if (dout !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: dout=%h expected 00000000", i, dout);
      end
    end
    step(1, 0, 0, 0, 1, 5, 1);
    drain();
  endtask

  task automatic test_fill;
    for (int i = 0; i < 320; i++) step(1, 1, 10'(i), {16'(i + 1), 16'(i)}, 0, 0, 1);
    for (int i = 0; i < 320; i++) step(1, 0, 0, 0, 1, 10'(i), 1);
    drain();
  endtask

  task automatic test_enable_gating;
    step(1, 1, 10'd1023, 32'h12345678, 0, 0, 1);
    step(1, 0, 10'd1023, 32'hFFFFFFFF, 0, 0, 1);
    step(1, 0, 0, 0, 1, 10'd1023, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, 10'(i * 37 + 2), 1);
      checks++;
      if (dout !== 32'h12345678) begin
        errors++;
        $display("FAIL ceb_hold cycle %0d: dout=%h expected 12345678", i, dout);
      end
    end
  endtask

  task automatic test_collision;
    step(1, 1, 10, 32'h11111111, 0, 0, 1);
    step(1, 1, 10, 32'h22222222, 1, 10, 1);
    step(1, 0, 0, 0, 1, 10, 1);
    drain();
  endtask

  task automatic test_concurrent;
    for (int i = 0; i < 320; i++)
      step(1, 1, 10'(i), {16'(i) ^ 16'hBEEF, 16'(i)}, i >= 2, 10'(i - 2), 1);
    drain();
  endtask

  task automatic test_reset_mid_stream;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 10'(i), 1);
    step(0, 0, 0, 0, 1, 4, 1);
    checks++;
    if (dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_stream: dout=%h expected 00000000", dout);
    end
    step(1, 0, 0, 0, 1, 5, 1);
    step(1, 0, 0, 0, 1, 6, 1);
    drain();
  endtask

  task automatic test_oce;
    logic [31:0] prev;
    step(1, 1, 7, 32'hC0DE0007, 0, 0, 1);
    drain();
    prev = dout;
    step(1, 0, 0, 0, 1, 7, 0);
`ifdef SDPB_OUTPUT_REG_EN
    checks++;
    if (dout !== prev) begin
      errors++;
      $display("FAIL oce_hold_1: dout=%h expected %h", dout, prev);
    end
    step(1, 0, 0, 0, 0, 9, 0);
    checks++;
    if (dout !== prev) begin
      errors++;
      $display("FAIL oce_hold_2: dout=%h expected %h", dout, prev);
    end
    step(1, 0, 0, 0, 0, 9, 1);
    checks++;
    if (dout !== 32'hC0DE0007) begin
      errors++;
      $display("FAIL oce_release: dout=%h expected c0de0007", dout);
    end
    step(1, 1, 7, 32'h77770007, 0, 0, 1);
    drain();
    step(1, 0, 0, 0, 1, 7, 1);
    checks++;
    if (dout !== 32'hC0DE0007) begin
      errors++;
      $display("FAIL latency2_early: dout=%h expected c0de0007", dout);
    end
    drain();
`else
    drain();
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = '0;
    test_reset();
    test_fill();
    test_enable_gating();
    test_collision();
    test_concurrent();
    test_reset_mid_stream();
    test_oce();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
